// File: rtl/lsu_ctrl.sv
// Load/store unit controller: alignment check, lane mask/data formatting for
// stores, and a one-deep blocking load with byte/halfword/word extension.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic              ls_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_result,
  output logic              load_result_valid,
  output logic              misaligned,
  output logic              mem_request,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_w_data,
  output logic [3:0]        mem_masking,
  output logic              mem_we_re,
  output logic              mem_load,
  input  logic              mem_valid,
  input  logic [31:0]       mem_r_data
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nx;
  logic              legal, aligned, op_ok, accept, accept_ld;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       lane, ext;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:ADDR_W+2]};

  always_comb begin
    legal = 1'b0;
    if (ls_store) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
  end

  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign op_ok     = (state == IDLE) && ls_valid && legal;
  assign accept    = op_ok && aligned;
  assign accept_ld = accept && !ls_store;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_ld) state_nx = WAIT;
      WAIT:    if (mem_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    mem_request = 1'b0;
    mem_address = '0;
    mem_w_data  = '0;
    mem_masking = '0;
    mem_we_re   = 1'b0;
    mem_load    = 1'b0;
    if (state == WAIT) begin
      stall       = 1'b1;
      mem_request = 1'b1;
      mem_address = waddr_q;
      mem_masking = '1;
    end else if (accept) begin
      mem_request = 1'b1;
      mem_address = addr[ADDR_W+1:2];
      if (ls_store) begin
        mem_we_re = 1'b1;
        case (funct3[1:0])
          2'b00: begin
            mem_masking = 4'b0001 << addr[1:0];
            mem_w_data  = {4{store_data[7:0]}};
          end
          2'b01: begin
            mem_masking = addr[1] ? 4'b1100 : 4'b0011;
            mem_w_data  = {2{store_data[15:0]}};
          end
          default: begin
            mem_masking = '1;
            mem_w_data  = store_data;
          end
        endcase
      end else begin
        stall       = 1'b1;
        mem_load    = 1'b1;
        mem_masking = '1;
      end
    end
  end

  assign lane = mem_r_data >> {off_q, 3'b000};

  always_comb begin
    ext = lane;
    case (f3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ext = {24'h0, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ext = {16'h0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_q             <= '0;
      f3_q              <= '0;
      waddr_q           <= '0;
      load_result       <= '0;
      load_result_valid <= 1'b0;
      misaligned        <= 1'b0;
    end else begin
      misaligned        <= op_ok && !aligned;
      load_result_valid <= 1'b0;
      if (accept_ld) begin
        off_q   <= addr[1:0];
        f3_q    <= funct3;
        waddr_q <= addr[ADDR_W+1:2];
      end
      if (state == WAIT && mem_valid) begin
        load_result       <= ext;
        load_result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-level reference memory, word memory
// environment answering loads one cycle later, random and directed ops.
module tb_lsu_ctrl;

  localparam int unsigned AW = 8;

  logic          clk, rst;
  logic          ls_valid, ls_store;
  logic [2:0]    funct3;
  logic [31:0]   addr, store_data;
  logic          stall, load_result_valid, misaligned;
  logic [31:0]   load_result;
  logic          mem_request, mem_we_re, mem_load, mem_valid;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_w_data, mem_r_data;
  logic [3:0]    mem_masking;

  lsu_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_store(ls_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
    .load_result(load_result), .load_result_valid(load_result_valid),
    .misaligned(misaligned), .mem_request(mem_request), .mem_address(mem_address),
    .mem_w_data(mem_w_data), .mem_masking(mem_masking), .mem_we_re(mem_we_re),
    .mem_load(mem_load), .mem_valid(mem_valid), .mem_r_data(mem_r_data)
  );

  typedef struct {
    bit          mis;
    logic [31:0] data;
    int unsigned cyc;
  } ev_t;

  ev_t         q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic [7:0]  ref_bytes [0:1023];
  logic [31:0] mem_arr   [0:255];
  bit          rd_pend = 0;
  logic [31:0] rd_word = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory environment: writes land at the end of the request cycle, loads
  // answer with mem_valid in the following cycle.
  initial begin
    mem_valid  = 1'b0;
    mem_r_data = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    forever begin
      @(negedge clk);
      mem_valid  = rd_pend;
      mem_r_data = rd_pend ? rd_word : $urandom;
      rd_pend    = 0;
      #3;
      if (mem_request && mem_we_re)
        for (int i = 0; i < 4; i++)
          if (mem_masking[i]) mem_arr[mem_address][8*i +: 8] = mem_w_data[8*i +: 8];
      if (mem_request && mem_load) begin
        rd_pend = 1;
        rd_word = mem_arr[mem_address];
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #3;
      if (load_result_valid || misaligned) begin
        if (q.size() == 0) begin
          chk("spurious_pulse", {30'b0, load_result_valid, misaligned}, 32'h0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {31'b0, misaligned}, {31'b0, e.mis});
          chk("pulse_cycle", cyc, e.cyc);
          if (!e.mis) chk("load_result", load_result, e.data);
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
    chk({tag, "_req"},   {31'b0, mem_request}, 32'h0);
    chk({tag, "_we"},    {31'b0, mem_we_re}, 32'h0);
    chk({tag, "_ld"},    {31'b0, mem_load}, 32'h0);
    chk({tag, "_mask"},  {28'b0, mem_masking}, 32'h0);
    chk({tag, "_wdata"}, mem_w_data, 32'h0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ls_valid   = 1'b0;
    ls_store   = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
    #3;
    check_quiet("idle");
  endtask

  task automatic issue(input bit st, input bit [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned size, off;
    bit          legal, acc, sgn;
    logic [3:0]  emask;
    logic [31:0] ewd, val;
    ev_t         e;
    @(negedge clk);
    ls_valid = 1'b1; ls_store = st; funct3 = f3; addr = a; store_data = d;
    #3;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    off   = a % 4;
    acc   = legal && (a % size == 0);
    emask = '0;
    ewd   = '0;
    if (acc && st) begin
      for (int unsigned i = 0; i < size; i++) emask[off + i] = 1'b1;
      for (int unsigned i = 0; i < 4; i++) ewd[8*i +: 8] = d[8*(i % size) +: 8];
    end else if (acc) begin
      emask = 4'hF;
    end
    chk("stall", {31'b0, stall}, {31'b0, acc && !st});
    chk("mem_request", {31'b0, mem_request}, {31'b0, acc});
    chk("mem_we_re", {31'b0, mem_we_re}, {31'b0, acc && st});
    chk("mem_load", {31'b0, mem_load}, {31'b0, acc && !st});
    chk("mem_masking", {28'b0, mem_masking}, {28'b0, emask});
    chk("mem_w_data", mem_w_data, ewd);
    if (acc) chk("mem_address", {24'b0, mem_address}, (a / 4) % 256);
    if (legal && !acc) begin
      e.mis = 1; e.data = '0; e.cyc = cyc + 1;
      q.push_back(e);
    end
    if (acc && st)
      for (int unsigned i = 0; i < size; i++) ref_bytes[(a + i) % 1024] = d[8*i +: 8];
    if (acc && !st) begin
      val = '0;
      for (int unsigned i = 0; i < size; i++) val[8*i +: 8] = ref_bytes[(a + i) % 1024];
      sgn = (f3[2] == 1'b0);
      if (sgn && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
      if (sgn && size == 2 && val[15]) val = val | 32'hFFFF_0000;
      e.mis = 0; e.data = val; e.cyc = cyc + 2;
      q.push_back(e);
      @(negedge clk);
      ls_valid = 1'($urandom); ls_store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; store_data = $urandom;
      #3;
      chk("wait_stall", {31'b0, stall}, 32'h1);
      chk("wait_req", {31'b0, mem_request}, 32'h1);
      chk("wait_we", {31'b0, mem_we_re}, 32'h0);
      chk("wait_ld", {31'b0, mem_load}, 32'h0);
      chk("wait_addr", {24'b0, mem_address}, (a / 4) % 256);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_bytes[i] = '0;
    rst = 1'b0; ls_valid = 1'b0; ls_store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    @(negedge clk); #3;
    check_quiet("reset");
    chk("reset_lrv", {31'b0, load_result_valid}, 32'h0);
    chk("reset_mis", {31'b0, misaligned}, 32'h0);
    chk("reset_lr", load_result, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    issue(1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(1, 3'd0, 32'h13, 32'h0000_00A5);
    issue(0, 3'd0, 32'h13, 32'h0);
    issue(0, 3'd4, 32'h13, 32'h0);
    issue(1, 3'd2, 32'h20, 32'h8001_7F02);
    issue(0, 3'd1, 32'h22, 32'h0);
    issue(0, 3'd5, 32'h22, 32'h0);
    issue(0, 3'd1, 32'h20, 32'h0);
    issue(0, 3'd2, 32'h21, 32'h0);
    issue(1, 3'd1, 32'h23, 32'h1234);
    issue(0, 3'd3, 32'h10, 32'h0);
    issue(1, 3'd4, 32'h10, 32'h55);
    issue(0, 3'd2, 32'h00, 32'h0);
    issue(0, 3'd2, 32'h04, 32'h0);
    idle_cycle();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(4) == 0) idle_cycle();
      else issue(1'($urandom), 3'($urandom), $urandom_range(95), $urandom);
    end
    idle_cycle();
    idle_cycle();

    // Reset while a load is outstanding: nothing may come back afterwards.
    @(negedge clk);
    ls_valid = 1'b1; ls_store = 1'b0; funct3 = 3'd2; addr = 32'h20;
    #3;
    chk("abort_issue_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    ls_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_quiet("abort_rst");
    chk("abort_lrv", {31'b0, load_result_valid}, 32'h0);
    chk("abort_mis", {31'b0, misaligned}, 32'h0);
    chk("abort_lr", load_result, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) idle_cycle();
    issue(0, 3'd1, 32'h22, 32'h0);
    for (int n = 0; n < 4; n++) idle_cycle();
    chk("queue_drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
